// File: rtl/spectral_recovery_ctrl_if.sv
// Handshake bundle between the spectral-recovery sequencer, the pixel source,
// the MAC datapath and the downstream spectrum writer.
interface spectral_recovery_ctrl_if #(
  parameter int PIXW = 8,
  parameter int IDXW = 19
);
  logic            start;
  logic            busy;
  logic            done;
  logic            pix_valid;
  logic            pix_ready;
  logic [PIXW-1:0] pix_red, pix_green, pix_blue;
  logic            dp_valid_in;
  logic [PIXW-1:0] dp_red, dp_green, dp_blue;
  logic            dp_valid_out;
  logic            res_valid;
  logic [IDXW-1:0] res_idx;
  logic            res_last;
  logic            res_credit;
  logic            err;

  // Controller side.
  modport slave (
    input  start, pix_valid, pix_red, pix_green, pix_blue, dp_valid_out, res_credit,
    output busy, done, pix_ready, dp_valid_in, dp_red, dp_green, dp_blue,
           res_valid, res_idx, res_last, err
  );

  // Environment side: pixel source, datapath and spectrum writer.
  modport master (
    output start, pix_valid, pix_red, pix_green, pix_blue, dp_valid_out, res_credit,
    input  busy, done, pix_ready, dp_valid_in, dp_red, dp_green, dp_blue,
           res_valid, res_idx, res_last, err
  );
endinterface

// File: rtl/spectral_recovery_ctrl.sv
// Frame sequencer for the 3-stage spectral-recovery MAC datapath: issues pixels
// under credit control, tags returning spectra with their index, flags protocol errors.
module spectral_recovery_ctrl #(
  parameter int NPIXELS = 307200,
  parameter int PIXW    = 8,
  parameter int IDXW    = 19,
  parameter int CREDITS = 4,
  parameter int CRW     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  spectral_recovery_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e          state_q;
  logic [CRW-1:0]  credits_q;
  logic [IDXW-1:0] issue_cnt_q;
  logic [IDXW-1:0] ret_cnt_q;
  logic            err_q;
  logic            dp_valid_q;
  logic [PIXW-1:0] dp_red_q, dp_green_q, dp_blue_q;

  logic pix_ready;
  logic accept;
  logic res_valid;
  logic res_last;
  logic last_accept;
  logic credits_full;
  logic stray_result;

  // Ready depends only on registered state so the source can never form a loop through it.
  assign pix_ready    = (state_q == RUN) && (credits_q != '0);
  assign accept       = bus.pix_valid && pix_ready;
  assign last_accept  = accept && (issue_cnt_q == IDXW'(NPIXELS - 1));
  assign credits_full = (credits_q == CRW'(CREDITS));

  // The datapath cannot stall, so results are forwarded the cycle they appear.
  assign res_valid    = bus.dp_valid_out && ((state_q == RUN) || (state_q == DRAIN));
  assign res_last     = res_valid && (ret_cnt_q == IDXW'(NPIXELS - 1));
  assign stray_result = bus.dp_valid_out && ((state_q == IDLE) || (state_q == DONE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      credits_q   <= CRW'(CREDITS);
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      err_q       <= 1'b0;
      dp_valid_q  <= 1'b0;
      dp_red_q    <= '0;
      dp_green_q  <= '0;
      dp_blue_q   <= '0;
    end else begin
      dp_valid_q <= accept;
      if (accept) begin
        dp_red_q    <= bus.pix_red;
        dp_green_q  <= bus.pix_green;
        dp_blue_q   <= bus.pix_blue;
        issue_cnt_q <= issue_cnt_q + IDXW'(1);
      end

      if (res_valid) ret_cnt_q <= ret_cnt_q + IDXW'(1);

      // A simultaneous accept and returned credit cancel out.
      if (accept && !bus.res_credit) begin
        credits_q <= credits_q - CRW'(1);
      end else if (!accept && bus.res_credit) begin
        if (credits_full) err_q <= 1'b1;
        else              credits_q <= credits_q + CRW'(1);
      end

      if (stray_result) err_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q     <= RUN;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
          end
        end
        RUN:     if (last_accept) state_q <= DRAIN;
        DRAIN:   if (res_last)    state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.pix_ready   = pix_ready;
  assign bus.dp_valid_in = dp_valid_q;
  assign bus.dp_red      = dp_red_q;
  assign bus.dp_green    = dp_green_q;
  assign bus.dp_blue     = dp_blue_q;
  assign bus.res_valid   = res_valid;
  assign bus.res_idx     = ret_cnt_q;
  assign bus.res_last    = res_last;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_spectral_recovery_ctrl.sv
// Bench for spectral_recovery_ctrl: 4-pixel frames, 2 credits, 3-cycle datapath delay line,
// randomized pixels/valid/credit timing against a cycle-counting reference model.
module tb_spectral_recovery_ctrl;
  localparam int NP   = 4;
  localparam int CR   = 2;
  localparam int PIXW = 8;
  localparam int IDXW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic force_dvo = 1'b0;
  logic [2:0] dl;
  int checks = 0;
  int failures = 0;
  int m_credits = CR;

  spectral_recovery_ctrl_if #(.PIXW(PIXW), .IDXW(IDXW)) b ();

  spectral_recovery_ctrl #(
    .NPIXELS(NP), .PIXW(PIXW), .IDXW(IDXW), .CREDITS(CR), .CRW(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: validIn reappears on validOut three cycles later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dl <= '0;
    else      dl <= {dl[1:0], b.dp_valid_in};
  end
  assign b.dp_valid_out = dl[2] | force_dvo;

  task automatic drive_idle;
    b.start = 1'b0; b.pix_valid = 1'b0; b.res_credit = 1'b0;
    b.pix_red = '0; b.pix_green = '0; b.pix_blue = '0;
  endtask

  task automatic do_reset;
    drive_idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    m_credits = CR;
  endtask

  task automatic do_start;
    @(posedge clk); #1 b.start = 1'b1; b.pix_valid = 1'b0; b.res_credit = 1'b0;
    @(posedge clk); #1 b.start = 1'b0;
  endtask

  task automatic test_reset;
    drive_idle();
    rst = 1'b0;
    b.pix_valid = 1'b1; b.start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({b.busy, b.done, b.pix_ready, b.dp_valid_in, b.res_valid, b.err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=000000",
               {b.busy, b.done, b.pix_ready, b.dp_valid_in, b.res_valid, b.err});
    end
    checks++;
    if ({b.dp_red, b.dp_green, b.dp_blue, b.res_idx, b.res_last} !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h want=0", {b.dp_red, b.dp_green, b.dp_blue, b.res_idx, b.res_last});
    end
    drive_idle();
    #1 rst = 1'b1;
    m_credits = CR;
    @(negedge clk);
    checks++;
    if (b.busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy got=%b want=0", b.busy); end
  endtask

  // One full frame checked cycle by cycle.
  // mode 0: credit returned one cycle after each result; mode 1: random credit delay.
  task automatic run_frame(input int mode, input bit rnd_valid, input string tag);
    int c, acc, ret, owed, last_ret, pulses;
    int acc_t[$];
    logic [3*PIXW-1:0] pend_pix;
    bit prev_acc, acc_now, exp_rdy, exp_rv, exp_done, exp_busy, fin, cred;
    do_start();
    c = 0; acc = 0; ret = 0; owed = 0; last_ret = -10; pulses = 0;
    prev_acc = 0; fin = 0; pend_pix = '0;
    while (!fin) begin
      b.pix_valid  = rnd_valid ? ($urandom_range(3) != 0) : 1'b1;
      {b.pix_red, b.pix_green, b.pix_blue} = 24'($urandom);
      cred = (owed > 0) && (mode == 0 || $urandom_range(1) == 0);
      b.res_credit = cred;
      @(negedge clk);
      exp_rdy  = (acc < NP) && (m_credits != 0);
      exp_rv   = (acc_t.size() > 0) && (acc_t[0] + 4 == c);
      exp_done = (c == last_ret + 1);
      exp_busy = !(ret == NP && c > last_ret + 1);
      checks++;
      if (b.pix_ready !== exp_rdy) begin
        failures++; $display("FAIL %s pix_ready cyc=%0d got=%b want=%b", tag, c, b.pix_ready, exp_rdy);
      end
      checks++;
      if (b.dp_valid_in !== prev_acc) begin
        failures++; $display("FAIL %s dp_valid_in cyc=%0d got=%b want=%b", tag, c, b.dp_valid_in, prev_acc);
      end
      if (prev_acc) begin
        checks++;
        if ({b.dp_red, b.dp_green, b.dp_blue} !== pend_pix) begin
          failures++;
          $display("FAIL %s dp_rgb cyc=%0d got=%h want=%h", tag, c, {b.dp_red, b.dp_green, b.dp_blue}, pend_pix);
        end
      end
      checks++;
      if (b.res_valid !== exp_rv) begin
        failures++; $display("FAIL %s res_valid cyc=%0d got=%b want=%b", tag, c, b.res_valid, exp_rv);
      end
      if (exp_rv) begin
        checks++;
        if (b.res_idx !== IDXW'(ret) || b.res_last !== (ret == NP - 1)) begin
          failures++;
          $display("FAIL %s res_idx/last cyc=%0d got=%0d/%b want=%0d/%b", tag, c, b.res_idx, b.res_last,
                   ret, (ret == NP - 1));
        end
      end
      checks++;
      if (b.done !== exp_done || b.busy !== exp_busy) begin
        failures++;
        $display("FAIL %s done/busy cyc=%0d got=%b/%b want=%b/%b", tag, c, b.done, b.busy, exp_done, exp_busy);
      end
      if (b.dp_valid_in === 1'b1) pulses++;
      acc_now = b.pix_valid && exp_rdy;
      if (acc_now) begin
        acc_t.push_back(c);
        pend_pix = {b.pix_red, b.pix_green, b.pix_blue};
        acc++;
      end
      prev_acc = acc_now;
      if (exp_rv) begin
        void'(acc_t.pop_front());
        ret++; owed++;
        if (ret == NP) last_ret = c;
      end
      if (cred) owed--;
      m_credits = m_credits + (cred ? 1 : 0) - (acc_now ? 1 : 0);
      fin = (ret == NP && c > last_ret + 1 && owed == 0) || c > 200;
      c++;
      @(posedge clk); #1;
    end
    b.pix_valid = 1'b0; b.res_credit = 1'b0;
    checks++;
    if (c > 201) begin failures++; $display("FAIL %s timeout cycles=%0d limit=200", tag, c); end
    checks++;
    if (pulses != NP) begin failures++; $display("FAIL %s issue_pulses got=%0d want=%0d", tag, pulses, NP); end
    checks++;
    if (b.err !== 1'b0) begin failures++; $display("FAIL %s err got=%b want=0", tag, b.err); end
  endtask

  task automatic test_frame;
    run_frame(0, 1'b0, "frame");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) run_frame(1, 1'b1, "b2b");
  endtask

  // Credit stall followed by a simultaneous accept and credit return at credits=1.
  task automatic test_credit_stall;
    int n_rdy;
    do_reset();
    do_start();
    b.pix_valid = 1'b1; b.res_credit = 1'b0; n_rdy = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b.pix_ready === 1'b1) n_rdy++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (n_rdy != 2 || b.pix_ready !== 1'b0 || b.busy !== 1'b1) begin
      failures++;
      $display("FAIL stall accepts=%0d rdy=%b busy=%b want 2/0/1", n_rdy, b.pix_ready, b.busy);
    end
    @(posedge clk); #1 b.res_credit = 1'b1;
    @(posedge clk); #1 b.res_credit = 1'b1;
    @(negedge clk);
    checks++;
    if (b.pix_ready !== 1'b1) begin failures++; $display("FAIL stall_release pix_ready got=%b want=1", b.pix_ready); end
    @(posedge clk); #1 b.res_credit = 1'b0; b.pix_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (b.pix_ready !== 1'b1 || b.err !== 1'b0 || b.dp_valid_in !== 1'b1) begin
      failures++;
      $display("FAIL accept_and_credit rdy/err/dvi got=%b/%b/%b want=1/0/1", b.pix_ready, b.err, b.dp_valid_in);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (b.pix_ready !== 1'b1) begin failures++; $display("FAIL credits_hold pix_ready got=%b want=1", b.pix_ready); end
  endtask

  task automatic test_errors;
    int n_rdy;
    do_reset();
    @(posedge clk); #1 force_dvo = 1'b1;
    @(negedge clk);
    checks++;
    if (b.res_valid !== 1'b0) begin failures++; $display("FAIL idle_result res_valid got=%b want=0", b.res_valid); end
    @(posedge clk); #1 force_dvo = 1'b0;
    @(negedge clk);
    checks++;
    if (b.err !== 1'b1) begin failures++; $display("FAIL idle_result err got=%b want=1", b.err); end
    do_reset();
    @(posedge clk); #1 b.res_credit = 1'b1;
    @(posedge clk); #1 b.res_credit = 1'b0;
    @(negedge clk);
    checks++;
    if (b.err !== 1'b1) begin failures++; $display("FAIL credit_overflow err got=%b want=1", b.err); end
    do_start();
    b.pix_valid = 1'b1; n_rdy = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (b.pix_ready === 1'b1) n_rdy++;
      @(posedge clk); #1;
    end
    checks++;
    if (n_rdy != CR) begin failures++; $display("FAIL credit_overflow accepts got=%0d want=%0d", n_rdy, CR); end
    b.pix_valid = 1'b0;
  endtask

  task automatic test_reset_midframe;
    do_reset();
    do_start();
    b.pix_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 b.pix_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (b.busy !== 1'b1 || b.dp_valid_in !== 1'b1) begin
      failures++; $display("FAIL midframe_pre busy/dvi got=%b/%b want=1/1", b.busy, b.dp_valid_in);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({b.busy, b.pix_ready, b.dp_valid_in, b.res_valid, b.done, b.err} !== 6'b0 ||
        {b.dp_red, b.dp_green, b.dp_blue} !== '0) begin
      failures++;
      $display("FAIL midframe_async flags got=%b rgb=%h want=0",
               {b.busy, b.pix_ready, b.dp_valid_in, b.res_valid, b.done, b.err}, {b.dp_red, b.dp_green, b.dp_blue});
    end
    @(posedge clk); #1 rst = 1'b1;
    m_credits = CR;
    run_frame(0, 1'b0, "after_reset");
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_frame();
    test_back_to_back();
    test_credit_stall();
    test_errors();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t limit=200000", $time);
    $fatal(1);
  end
endmodule
